accum_arbiter: RTL and testbench

Two-port round-robin scheduler that shares one accumulator datapath (W-bit register fed back through a W-bit adder with carry-in) between two requesters. Each requester issues a command (load, add, add-with-carry, clear) with an operand over a REQ/ACK handshake. The block arbitrates, latches the winning command, sequences the register update and returns the acknowledge. It sits between the requesting control logic and the accumulator register/adder pair, and owns the register's enable and clear.

---
 rtl/accum_arbiter_if.sv | 19 +
 rtl/accum_arbiter.sv | 53 +++++
 tb/tb_accum_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/accum_arbiter_if.sv
// accum_arbiter_if: request/command/acknowledge bundle between two requesters and the accumulator scheduler
interface accum_arbiter_if #(parameter int W = 8);
    logic         REQ0, REQ1;
    logic [1:0]   OP0, OP1;
    logic [W-1:0] D0, D1;
    logic         GNT0, GNT1;
    logic         ACK0, ACK1;
    logic         BUSY;
    logic [W-1:0] Q;
    logic         CO;
    modport master (
        output REQ0, REQ1, OP0, OP1, D0, D1,
        input  GNT0, GNT1, ACK0, ACK1, BUSY, Q, CO
    );
    modport slave (
        input  REQ0, REQ1, OP0, OP1, D0, D1,
        output GNT0, GNT1, ACK0, ACK1, BUSY, Q, CO
    );
endinterface

// File: rtl/accum_arbiter.sv
// accum_arbiter: round-robin scheduler sharing one W-bit accumulator/adder between two requesters
module accum_arbiter #(parameter int W = 8) (
    input logic CK,
    input logic CLR,
    accum_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;
    state_t state, nxt;
    logic last, win, pick, any, co;
    logic [1:0] op;
    logic [W-1:0] d, q;
    logic [W:0] sum;
    // next state, tie-break winner and adder; only ADDC (10) feeds the carry back in
    always_comb begin
        any  = bus.REQ0 | bus.REQ1;
        pick = (bus.REQ0 & bus.REQ1) ? ~last : bus.REQ1;
        nxt  = state == IDLE ? (any ? EXEC : IDLE) : state == EXEC ? ACK : IDLE;
        sum  = {1'b0, q} + {1'b0, d} + {{W{1'b0}}, op == 2'b10 && co};
    end
    // state register
    always_ff @(posedge CK or negedge CLR)
        if (!CLR) state <= IDLE;
        else      state <= nxt;
    // arbitration pointer and command latch, captured on the grant edge only
    always_ff @(posedge CK or negedge CLR)
        if (!CLR) begin
            last <= 1'b1;
            win  <= 1'b0;
            op   <= 2'b00;
            d    <= '0;
        end else if (state == IDLE && any) begin
            last <= pick;
            win  <= pick;
            op   <= pick ? bus.OP1 : bus.OP0;
            d    <= pick ? bus.D1 : bus.D0;
        end
    // accumulator update at the edge closing EXEC; ADD/ADDC (op bits differ) produce a carry
    always_ff @(posedge CK or negedge CLR)
        if (!CLR) begin
            q  <= '0;
            co <= 1'b0;
        end else if (state == EXEC) begin
            q  <= op == 2'b11 ? '0 : op == 2'b00 ? d : sum[W-1:0];
            co <= (op[1] ^ op[0]) ? sum[W] : 1'b0;
        end
    assign bus.GNT0 = state == EXEC && !win;
    assign bus.GNT1 = state == EXEC && win;
    assign bus.ACK0 = state == ACK && !win;
    assign bus.ACK1 = state == ACK && win;
    assign bus.BUSY = state != IDLE;
    assign bus.Q    = q;
    assign bus.CO   = co;
endmodule

// File: tb/tb_accum_arbiter.sv
// tb_accum_arbiter: directed scoreboard bench for the two-port accumulator scheduler
module tb_accum_arbiter;
    typedef struct {
        logic       who;
        logic [7:0] q;
        logic       co;
    } exp_t;
    logic ck = 1'b0;
    logic clr = 1'b0;
    int tests = 0;
    int fails = 0;
    exp_t sb[$];
    logic [7:0] mq = 8'h00;
    logic mco = 1'b0;
    accum_arbiter_if #(.W(8)) bus();
    accum_arbiter #(.W(8)) dut (.CK(ck), .CLR(clr), .bus(bus.slave));
    always #5 ck = ~ck;
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc;
        @(posedge ck);
        #1;
    endtask
    task automatic drive(input bit who, input bit req, input logic [1:0] op, input logic [7:0] d);
        if (who) begin
            bus.REQ1 = req; bus.OP1 = op; bus.D1 = d;
        end else begin
            bus.REQ0 = req; bus.OP0 = op; bus.D0 = d;
        end
    endtask
    task automatic push(input bit who, input logic [1:0] op, input logic [7:0] d);
        logic [8:0] s;
        case (op)
            2'b00: begin mq = d; mco = 1'b0; end
            2'b01: begin s = {1'b0, mq} + {1'b0, d}; {mco, mq} = s; end
            2'b10: begin s = {1'b0, mq} + {1'b0, d} + {8'h00, mco}; {mco, mq} = s; end
            default: begin mq = 8'h00; mco = 1'b0; end
        endcase
        sb.push_back('{who, mq, mco});
    endtask
    task automatic issue(input bit who, input logic [1:0] op, input logic [7:0] d);
        drive(who, 1'b1, op, d);
        push(who, op, d);
        cyc;
        check("gnt", {14'b0, bus.GNT1, bus.GNT0}, who ? 16'd2 : 16'd1);
        check("busy_exec", {15'b0, bus.BUSY}, 16'd1);
        drive(who, 1'b0, 2'b00, 8'h00);
        cyc;
        cyc;
        check("busy_idle", {15'b0, bus.BUSY}, 16'd0);
    endtask
    // scoreboard: every acknowledge must match the next expected completion
    always @(posedge ck) begin
        #1;
        if (bus.ACK0 | bus.ACK1) begin
            if (sb.size() == 0) check("spurious_ack", {14'b0, bus.ACK1, bus.ACK0}, 16'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_who", {14'b0, bus.ACK1, bus.ACK0}, e.who ? 16'd2 : 16'd1);
                check("ack_q", {8'b0, bus.Q}, {8'b0, e.q});
                check("ack_co", {15'b0, bus.CO}, {15'b0, e.co});
            end
        end
    end
    initial begin
        drive(0, 1'b0, 2'b00, 8'h00);
        drive(1, 1'b0, 2'b00, 8'h00);
        #1;
        check("rst_q", {8'b0, bus.Q}, 16'h0);
        check("rst_outs", {10'b0, bus.CO, bus.BUSY, bus.GNT1, bus.GNT0, bus.ACK1, bus.ACK0}, 16'h0);
        cyc;
        cyc;
        clr = 1'b1;
        issue(0, 2'b00, 8'h5A);
        issue(0, 2'b01, 8'hC0);
        drive(0, 1'b1, 2'b10, 8'h01);
        cyc;
        check("mid_gnt", {15'b0, bus.GNT0}, 16'd1);
        clr = 1'b0;
        #1;
        check("mid_q", {8'b0, bus.Q}, 16'h0);
        check("mid_outs", {10'b0, bus.CO, bus.BUSY, bus.GNT1, bus.GNT0, bus.ACK1, bus.ACK0}, 16'h0);
        drive(0, 1'b0, 2'b00, 8'h00);
        mq = 8'h00;
        mco = 1'b0;
        cyc;
        cyc;
        check("mid_noack", {14'b0, bus.ACK1, bus.ACK0}, 16'd0);
        clr = 1'b1;
        drive(0, 1'b1, 2'b00, 8'h11);
        drive(1, 1'b1, 2'b00, 8'h22);
        push(0, 2'b00, 8'h11);
        push(1, 2'b00, 8'h22);
        cyc;
        check("tie_first", {14'b0, bus.GNT1, bus.GNT0}, 16'd1);
        drive(0, 1'b0, 2'b00, 8'h00);
        cyc;
        cyc;
        cyc;
        check("tie_second", {14'b0, bus.GNT1, bus.GNT0}, 16'd2);
        drive(1, 1'b0, 2'b00, 8'h00);
        cyc;
        cyc;
        check("tie_idle", {15'b0, bus.BUSY}, 16'd0);
        issue(0, 2'b00, 8'hF0);
        issue(0, 2'b01, 8'h20);
        issue(0, 2'b10, 8'h01);
        issue(1, 2'b11, 8'hAB);
        drive(0, 1'b1, 2'b01, 8'h01);
        drive(1, 1'b1, 2'b01, 8'h01);
        for (int i = 0; i < 4; i++) push(i[0], 2'b01, 8'h01);
        for (int i = 0; i < 4; i++) begin
            cyc;
            check("rr_gnt", {14'b0, bus.GNT1, bus.GNT0}, i[0] ? 16'd2 : 16'd1);
            cyc;
            check("rr_ack", {14'b0, bus.ACK1, bus.ACK0}, i[0] ? 16'd2 : 16'd1);
            cyc;
        end
        drive(0, 1'b0, 2'b00, 8'h00);
        drive(1, 1'b0, 2'b00, 8'h00);
        check("rr_q", {8'b0, bus.Q}, 16'h04);
        drive(1, 1'b1, 2'b00, 8'h33);
        push(1, 2'b00, 8'h33);
        cyc;
        check("latch_gnt", {14'b0, bus.GNT1, bus.GNT0}, 16'd2);
        drive(1, 1'b0, 2'b01, 8'hCC);
        cyc;
        cyc;
        issue(0, 2'b01, 8'h07);
        cyc;
        check("no_retake", {15'b0, bus.BUSY}, 16'd0);
        check("late_q", {8'b0, bus.Q}, 16'h3A);
        for (int i = 0; i < 10 && sb.size() != 0; i++) cyc;
        check("sb_empty", sb.size(), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
